bcd_7seg_scanner: RTL

- Downstream consumer of the 3-digit combinational binary-to-BCD converter in the FPGA wrapper.
- Accepts a 12-bit packed BCD value through a valid/ready handshake and double-buffers it.
- Time-multiplexes the three digits onto one shared active-low 7-segment bus with per-digit active-low anodes.
- Inserts a dead-time guard at the start of each digit slot to suppress ghosting.

---
 rtl/bcd_7seg_scanner_if.sv | 9 +
 rtl/bcd_7seg_scanner.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scanner_if.sv
// Valid/ready load channel carrying a packed 3-digit BCD value {hundreds, tens, ones}.
interface bcd_7seg_scanner_if;
   logic        bcd_valid;
   logic        bcd_ready;
   logic [11:0] bcd;

   modport master (output bcd_valid, output bcd, input bcd_ready);
   modport slave  (input bcd_valid, input bcd, output bcd_ready);
endinterface

// File: rtl/bcd_7seg_scanner.sv
// Double-buffered 3-digit BCD scanner for a shared active-low 7-segment bus with guard blanking.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (hundreds, then tens).
module bcd_7seg_scanner #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   bcd_7seg_scanner_if.slave         bus,
   output logic [6:0]                seg,
   output logic [2:0]                an,
   output logic                      frame_tick
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {
      DIG_ONES = 2'd0,
      DIG_TENS = 2'd1,
      DIG_HUNS = 2'd2
   } dig_t;

   dig_t          idx, idx_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [11:0]   disp;
   logic [11:0]   pending;
   logic          pending_full;

   logic          tick;
   logic          frame;
   logic          in_guard;
   logic          blank;
   logic [3:0]    nib;
   logic [2:0]    an_nxt;
   logic [6:0]    seg_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign bus.bcd_ready = !pending_full;

   always_comb begin
      tick     = (cnt == CW'(REFRESH_DIV - 1));
      frame    = tick && (idx == DIG_HUNS);
      cnt_nxt  = tick ? '0 : cnt + 1'b1;
      idx_nxt  = idx;
      if (tick) begin
         case (idx)
            DIG_ONES: idx_nxt = DIG_TENS;
            DIG_TENS: idx_nxt = DIG_HUNS;
            default:  idx_nxt = DIG_ONES;
         endcase
      end
   end

   always_comb begin
      in_guard = (32'(cnt) < GUARD);
      nib      = disp[3:0];
      an_nxt   = 3'b111;
      case (idx)
         DIG_ONES: begin nib = disp[3:0];  an_nxt = 3'b110; end
         DIG_TENS: begin nib = disp[7:4];  an_nxt = 3'b101; end
         DIG_HUNS: begin nib = disp[11:8]; an_nxt = 3'b011; end
         default:  begin nib = disp[3:0];  an_nxt = 3'b111; end
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      blank = ((idx == DIG_HUNS) && (disp[11:8] == 4'd0)) ||
              ((idx == DIG_TENS) && (disp[11:4] == 8'd0));
`else
      blank = 1'b0;
`endif
      seg_nxt = seg_decode(nib);
      if (in_guard || blank) begin
         an_nxt  = 3'b111;
         seg_nxt = 7'h7F;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         idx          <= DIG_ONES;
         disp         <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         an           <= '1;
         seg          <= '1;
         frame_tick   <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         an         <= an_nxt;
         seg        <= seg_nxt;
         frame_tick <= frame;
         // Capture and transfer are exclusive: ready is low whenever a transfer is possible.
         if (bus.bcd_valid && !pending_full) begin
            pending      <= bus.bcd;
            pending_full <= 1'b1;
         end else if (frame && pending_full) begin
            disp         <= pending;
            pending_full <= 1'b0;
         end
      end
   end

endmodule
